// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX data memory: access sizes, controller states and word geometry.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Bytes touched by one access; the reserved encoding 2'b11 behaves as a word.
    function automatic int access_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            default: return BYTES_PER_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: write byte-enables/replicated write data and right-aligned,
// optionally sign-extended read data for byte, half and word accesses.
module mem_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        byte_en  = 4'b1111;
        wr_word  = wdata;
        rd_data  = mem_word;
        byte_sel = 8'h00;
        half_sel = addr_lo[1] ? mem_word[15:0] : mem_word[31:16];

        // Lane 0 (lowest address) lives in bits 31:24.
        case (addr_lo)
            2'd0:    byte_sel = mem_word[31:24];
            2'd1:    byte_sel = mem_word[23:16];
            2'd2:    byte_sel = mem_word[15:8];
            default: byte_sel = mem_word[7:0];
        endcase

        case (size)
            SZ_BYTE: begin
                byte_en = 4'b1000 >> addr_lo;
                wr_word = {4{wdata[7:0]}};
                rd_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                byte_en = addr_lo[1] ? 4'b0011 : 4'b1100;
                wr_word = {2{wdata[15:0]}};
                rd_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = wdata;
                rd_data = mem_word;
            end
        endcase
    end

endmodule

// File: rtl/rwmem_lat.sv
// Byte-addressable big-endian data memory with a programmable access latency,
// one request at a time over an enable / data_ready handshake.
module rwmem_lat
    import dlx_mem_pkg::*;
#(
    parameter int    WORD_SIZE      = 32,
    parameter int    ADDRESS_SIZE   = 16,
    parameter int    MEM_BYTES      = 2 ** ADDRESS_SIZE,
    parameter int    DATA_DELAY     = 2,
    parameter string FILE_PATH_INIT = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    read_not_write,
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0]    wdata,
    output logic [WORD_SIZE-1:0]    rdata,
    output logic                    data_ready,
    output logic                    busy,
    output logic                    error
);

    localparam int                    IDX_W     = $clog2(MEM_BYTES);
    localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE + 1)'(MEM_BYTES);

    typedef struct packed {
        logic                    read_not_write;
        logic [1:0]              size;
        logic                    sign_ext;
        logic [ADDRESS_SIZE-1:0] address;
        logic [WORD_SIZE-1:0]    wdata;
    } mem_req_t;

    mem_state_t state, state_next;
    logic [3:0] delay_cnt;
    mem_req_t   req_q;

    logic [7:0]            mem [MEM_BYTES];
    logic [IDX_W-1:0]      lane_idx [BYTES_PER_WORD];
    logic [31:0]           mem_word;
    logic [3:0]            byte_en;
    logic [WORD_SIZE-1:0]  wr_word;
    logic [WORD_SIZE-1:0]  rd_data;
    logic [ADDRESS_SIZE:0] last_byte;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  access_err;
    logic                  do_write;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = (DATA_DELAY == 0) ? DONE : WAIT;
            WAIT:    if (delay_cnt <= 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last byte is computed one bit wider so an access straddling the top of the address space still flags.
    always_comb begin
        last_byte    = {1'b0, req_q.address} + (ADDRESS_SIZE + 1)'(access_bytes(req_q.size) - 1);
        misaligned   = (req_q.size == SZ_HALF && req_q.address[0])
                     || (req_q.size[1] && req_q.address[1:0] != 2'b00);
        out_of_range = last_byte >= MEM_LIMIT;
        access_err   = misaligned || out_of_range;
        do_write     = (state == DONE) && !req_q.read_not_write && !access_err;
    end

    always_comb begin
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            lane_idx[k] = IDX_W'({req_q.address[ADDRESS_SIZE-1:2], 2'(k)});
            mem_word[8*(BYTES_PER_WORD-1-k) +: 8] = mem[lane_idx[k]];
        end
    end

    mem_lane_align u_lane_align (
        .size     (req_q.size),
        .addr_lo  (req_q.address[1:0]),
        .sign_ext (req_q.sign_ext),
        .wdata    (req_q.wdata),
        .mem_word (mem_word),
        .byte_en  (byte_en),
        .wr_word  (wr_word),
        .rd_data  (rd_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            delay_cnt  <= 4'd0;
            rdata      <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            data_ready <= (state == DONE);
            error      <= (state == DONE) && access_err;
            if (state == IDLE && enable) begin
                delay_cnt <= 4'(DATA_DELAY);
            end else if (state == WAIT) begin
                delay_cnt <= delay_cnt - 4'd1;
            end
            if (state == DONE && req_q.read_not_write) begin
                rdata <= access_err ? '0 : rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && enable) begin
            req_q <= '{read_not_write: read_not_write, size: size, sign_ext: sign_ext,
                       address: address, wdata: wdata};
        end
    end

    // NOTE: the byte array has no reset; its contents survive rst and change only on a completing write.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (byte_en[BYTES_PER_WORD-1-k]) begin
                    mem[lane_idx[k]] <= wr_word[8*(BYTES_PER_WORD-1-k) +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rwmem_lat.sv
// Self-checking bench for rwmem_lat: one instance with DATA_DELAY=2 and one with DATA_DELAY=0,
// both 256 bytes deep, checked against a byte-array reference model.
module tb_rwmem_lat;
    import dlx_mem_pkg::*;

    localparam int MEM_BYTES = 256;
    localparam int AW        = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en2, en0, read_not_write, sign_ext;
    logic [1:0]    size;
    logic [AW-1:0] address;
    logic [31:0]   wdata;
    logic [31:0]   rdata2, rdata0;
    logic          dr2, dr0, busy2, busy0, err2, err0;

    rwmem_lat #(.WORD_SIZE(32), .ADDRESS_SIZE(AW), .MEM_BYTES(MEM_BYTES), .DATA_DELAY(2), .FILE_PATH_INIT("")) u_d2 (
        .clk(clk), .rst(rst), .enable(en2), .read_not_write(read_not_write), .size(size),
        .sign_ext(sign_ext), .address(address), .wdata(wdata), .rdata(rdata2),
        .data_ready(dr2), .busy(busy2), .error(err2));

    rwmem_lat #(.WORD_SIZE(32), .ADDRESS_SIZE(AW), .MEM_BYTES(MEM_BYTES), .DATA_DELAY(0), .FILE_PATH_INIT("")) u_d0 (
        .clk(clk), .rst(rst), .enable(en0), .read_not_write(read_not_write), .size(size),
        .sign_ext(sign_ext), .address(address), .wdata(wdata), .rdata(rdata0),
        .data_ready(dr0), .busy(busy0), .error(err0));

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem_m [2][MEM_BYTES];
    logic [31:0] last_rd [2];
    time         last_acc [2];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int delay_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // d=0 drives the DATA_DELAY=2 instance, d=1 the DATA_DELAY=0 instance.
    task automatic do_op(input int d, input logic rnw, input logic [1:0] sz, input logic sx,
                         input logic [AW-1:0] addr, input logic [31:0] wd, input string tag,
                         output logic [31:0] rd_obs, output logic err_obs);
        int          n;
        int          lat;
        bit          seen;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [31:0] v;
        n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_err = (int'(addr) % n != 0) || (int'(addr) + n > MEM_BYTES);
        exp_rd  = last_rd[d];
        if (rnw) begin
            if (exp_err) begin
                exp_rd = 32'h0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_m[d][int'(addr) + i]);
                if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                exp_rd = v;
            end
        end

        @(negedge clk);
        read_not_write = rnw;
        size           = sz;
        sign_ext       = sx;
        address        = addr;
        wdata          = wd;
        if (d == 0) en2 = 1'b1; else en0 = 1'b1;
        @(posedge clk);
        last_acc[d] = $time;
        #1;
        en2 = 1'b0;
        en0 = 1'b0;
        {read_not_write, sign_ext, size} = 4'($urandom);
        address = 16'($urandom);
        wdata   = $urandom;
        check({tag, "/busy_after_accept"}, 32'((d == 0) ? busy2 : busy0), 32'd1);
        check({tag, "/ready_low_after_accept"}, 32'((d == 0) ? dr2 : dr0), 32'd0);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = (d == 0) ? dr2 : dr0;
        end
        rd_obs  = (d == 0) ? rdata2 : rdata0;
        err_obs = (d == 0) ? err2 : err0;
        check({tag, "/latency"}, 32'(lat), 32'(delay_of(d) + 1));
        check({tag, "/error"}, 32'(err_obs), 32'(exp_err));
        check({tag, "/rdata"}, rd_obs, exp_rd);
        check({tag, "/busy_at_ready"}, 32'((d == 0) ? busy2 : busy0), 32'd0);

        if (!rnw && !exp_err) begin
            for (int i = 0; i < n; i++) mem_m[d][int'(addr) + i] = 8'(wd >> (8 * (n - 1 - i)));
        end
        last_rd[d] = exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        time         t0;
        bit          seen;

        rst            = 1'b1;
        en2            = 1'b0;
        en0            = 1'b0;
        read_not_write = 1'b0;
        size           = 2'b00;
        sign_ext       = 1'b0;
        address        = '0;
        wdata          = '0;
        last_rd[0]     = 32'h0;
        last_rd[1]     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/rdata2", rdata2, 32'h0);
        check("reset/ready2", 32'(dr2), 32'd0);
        check("reset/busy2", 32'(busy2), 32'd0);
        check("reset/error2", 32'(err2), 32'd0);
        check("reset/rdata0", rdata0, 32'h0);
        check("reset/ready0", 32'(dr0), 32'd0);
        check("reset/busy0", 32'(busy0), 32'd0);
        check("reset/error0", 32'(err0), 32'd0);
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < MEM_BYTES; a += 4) begin
                do_op(d, 1'b0, SZ_WORD, 1'b0, 16'(a), $urandom, "fill", rd, er);
            end
        end

        do_op(0, 1'b0, SZ_WORD, 1'b0, 16'h0010, 32'hDEAD_BEEF, "w_word", rd, er);
        t0 = last_acc[0];
        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h0010, 32'h0, "r_word", rd, er);
        check("r_word/literal", rd, 32'hDEAD_BEEF);
        check("d2_spacing", 32'(last_acc[0] - t0), 32'd40);
        do_op(0, 1'b1, SZ_BYTE, 1'b0, 16'h0010, 32'h0, "r_byte", rd, er);
        check("r_byte/literal", rd, 32'h0000_00DE);

        do_op(0, 1'b0, SZ_BYTE, 1'b0, 16'h0020, 32'h1234_5600, "w_byte20", rd, er);
        do_op(0, 1'b0, SZ_BYTE, 1'b0, 16'h0021, 32'hABCD_EF80, "w_byte21", rd, er);
        do_op(0, 1'b0, SZ_HALF, 1'b0, 16'h0022, 32'h5555_8001, "w_half22", rd, er);
        do_op(0, 1'b1, SZ_BYTE, 1'b1, 16'h0021, 32'h0, "r_byte_sx", rd, er);
        check("r_byte_sx/literal", rd, 32'hFFFF_FF80);
        do_op(0, 1'b1, SZ_BYTE, 1'b0, 16'h0021, 32'h0, "r_byte_zx", rd, er);
        check("r_byte_zx/literal", rd, 32'h0000_0080);
        do_op(0, 1'b1, SZ_HALF, 1'b1, 16'h0022, 32'h0, "r_half_sx", rd, er);
        check("r_half_sx/literal", rd, 32'hFFFF_8001);
        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h0020, 32'h0, "r_word20", rd, er);
        check("r_word20/literal", rd, 32'h0080_8001);

        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h0013, 32'h0, "mis_rd", rd, er);
        check("mis_rd/error_literal", 32'(er), 32'd1);
        check("mis_rd/rdata_literal", rd, 32'h0);
        do_op(0, 1'b0, SZ_WORD, 1'b0, 16'h0012, 32'h0BAD_0BAD, "mis_wr", rd, er);
        check("mis_wr/error_literal", 32'(er), 32'd1);
        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h0010, 32'h0, "mis_wr_readback", rd, er);
        check("mis_wr_readback/literal", rd, 32'hDEAD_BEEF);
        do_op(0, 1'b1, SZ_HALF, 1'b0, 16'h0011, 32'h0, "mis_half", rd, er);

        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h00FE, 32'h0, "oor_word", rd, er);
        check("oor_word/error_literal", 32'(er), 32'd1);
        do_op(0, 1'b1, SZ_BYTE, 1'b0, 16'h00FF, 32'h0, "edge_byte", rd, er);
        check("edge_byte/error_literal", 32'(er), 32'd0);
        do_op(0, 1'b1, SZ_HALF, 1'b0, 16'h00FE, 32'h0, "edge_half", rd, er);
        do_op(0, 1'b1, 2'b11, 1'b0, 16'h0010, 32'h0, "rsvd_size", rd, er);
        check("rsvd_size/literal", rd, 32'hDEAD_BEEF);

        // Reset lands while the write to 0x40 is still counting down.
        @(negedge clk);
        read_not_write = 1'b0;
        size           = SZ_WORD;
        address        = 16'h0040;
        wdata          = 32'hCAFE_F00D;
        en2            = 1'b1;
        @(posedge clk);
        #1;
        en2 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort/busy", 32'(busy2), 32'd0);
        check("abort/ready", 32'(dr2), 32'd0);
        check("abort/rdata2", rdata2, 32'h0);
        check("abort/rdata0", rdata0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (dr2) seen = 1'b1;
        end
        check("abort/no_ready_later", 32'(seen), 32'd0);
        do_op(0, 1'b1, SZ_WORD, 1'b0, 16'h0040, 32'h0, "abort_readback", rd, er);

        do_op(1, 1'b0, SZ_WORD, 1'b0, 16'h0080, 32'h1357_9BDF, "d0_w", rd, er);
        t0 = last_acc[1];
        do_op(1, 1'b1, SZ_WORD, 1'b0, 16'h0080, 32'h0, "d0_r", rd, er);
        check("d0_r/literal", rd, 32'h1357_9BDF);
        check("d0_spacing", 32'(last_acc[1] - t0), 32'd20);
        t0 = last_acc[1];
        do_op(1, 1'b1, SZ_HALF, 1'b1, 16'h0082, 32'h0, "d0_half", rd, er);
        check("d0_half/literal", rd, 32'hFFFF_9BDF);
        check("d0_spacing2", 32'(last_acc[1] - t0), 32'd20);

        for (int i = 0; i < 200; i++) begin
            int            d;
            logic [AW-1:0] a;
            d = $urandom_range(0, 1);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, MEM_BYTES - 1));
            do_op(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rand", rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
